// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM state encoding and alignment helpers.
package lsu_pkg;

    localparam int LSU_WIDTH = 32;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_store(input logic [2:0] op);
        return op >= OP_SB;
    endfunction

    // offset[1] is the least significant address bit (big-endian bit numbering)
    function automatic logic is_misaligned(input logic [2:0] op, input logic [0:1] offset);
        case (op)
            OP_LH, OP_LHU, OP_SH: return offset[1];
            OP_LW, OP_SW:         return |offset;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword lane out of a big-endian read word and sign/zero extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [0:1]  offset,
    input  logic [0:31] rdata,
    output logic [0:31] result
);

    logic [0:7]  lane_byte;
    logic [0:15] lane_half;

    always_comb begin
        case (offset)
            2'd0:    lane_byte = rdata[0:7];
            2'd1:    lane_byte = rdata[8:15];
            2'd2:    lane_byte = rdata[16:23];
            default: lane_byte = rdata[24:31];
        endcase
        lane_half = offset[0] ? rdata[16:31] : rdata[0:15];

        case (mem_op)
            OP_LB:   result = {{24{lane_byte[0]}}, lane_byte};
            OP_LBU:  result = {24'd0, lane_byte};
            OP_LH:   result = {{16{lane_half[0]}}, lane_half};
            OP_LHU:  result = {16'd0, lane_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage with req/ack data-memory handshake and processor stall.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = LSU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       memOp,
    input  logic [0:WIDTH-1] addr,
    input  logic [0:WIDTH-1] storeData,
    output logic [0:WIDTH-1] loadData,
    output logic             done,
    output logic             stall,
    output logic             misalign,
    output logic             dmemReq,
    output logic             dmemWe,
    output logic [0:WIDTH-1] dmemAddr,
    output logic [0:WIDTH-1] dmemWdata,
    output logic [0:3]       dmemByteEn,
    input  logic [0:WIDTH-1] dmemRdata,
    input  logic             dmemAck
);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [0:WIDTH-1] addr_q;
    logic [0:WIDTH-1] data_q;
    logic [0:WIDTH-1] load_q;
    logic [0:WIDTH-1] aligned;
    logic             mis_q;
    logic             mis_now;
    logic             req_active;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis_now = is_misaligned(memOp, addr[WIDTH-2:WIDTH-1]);
`else
    assign mis_now = 1'b0;
`endif

    lsu_load_align u_align (
        .mem_op (op_q),
        .offset (addr_q[WIDTH-2:WIDTH-1]),
        .rdata  (dmemRdata),
        .result (aligned)
    );

    // Operands are captured once in IDLE so the request stays stable however long memory takes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            load_q <= '0;
            mis_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= memOp;
                        addr_q <= addr;
                        data_q <= storeData;
                        mis_q  <= mis_now;
                        state  <= mis_now ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmemAck) begin
                        state <= ST_DONE;
                        if (!is_store(op_q)) begin
                            load_q <= aligned;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_active = (state == ST_REQ);

    // Request bus is zero outside REQ so idle and reset present a quiet interface
    always_comb begin
        dmemAddr   = '0;
        dmemWe     = 1'b0;
        dmemWdata  = '0;
        dmemByteEn = '0;
        if (req_active) begin
            dmemAddr = {addr_q[0:WIDTH-3], 2'b00};
            dmemWe   = is_store(op_q);
            case (op_q)
                OP_SB: begin
                    dmemWdata  = {4{data_q[24:31]}};
                    dmemByteEn = 4'b1000 >> addr_q[WIDTH-2:WIDTH-1];
                end
                OP_SH: begin
                    dmemWdata  = {2{data_q[16:31]}};
                    dmemByteEn = addr_q[WIDTH-2] ? 4'b0011 : 4'b1100;
                end
                OP_SW: begin
                    dmemWdata  = data_q;
                    dmemByteEn = 4'b1111;
                end
                default: begin
                    dmemWdata  = '0;
                    dmemByteEn = 4'b1111;
                end
            endcase
        end
    end

    assign dmemReq  = req_active;
    assign done     = (state == ST_DONE);
    assign misalign = done & mis_q;
    assign stall    = reset & (((state == ST_IDLE) & start) | req_active);
    assign loadData = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: spec vectors, reset abort, misalign case and random ops.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  memOp;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic        done;
    logic        stall;
    logic        misalign;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemByteEn;
    logic [31:0] dmemRdata;
    logic        dmemAck;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_ld = '0;

    load_store_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .memOp      (memOp),
        .addr       (addr),
        .storeData  (storeData),
        .loadData   (loadData),
        .done       (done),
        .stall      (stall),
        .misalign   (misalign),
        .dmemReq    (dmemReq),
        .dmemWe     (dmemWe),
        .dmemAddr   (dmemAddr),
        .dmemWdata  (dmemWdata),
        .dmemByteEn (dmemByteEn),
        .dmemRdata  (dmemRdata),
        .dmemAck    (dmemAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          lat;
        logic [31:0] exp_load;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference model written from the architectural rules with plain arithmetic
    function automatic logic m_is_load(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic m_misaligned(input logic [2:0] op, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
        if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
        int unsigned off, v;
        off = a % 4;
        case (op)
            OP_LB, OP_LBU: begin
                v = (rd >> (8 * (3 - off))) & 32'hFF;
                if (op == OP_LB && v >= 128) v = v + 32'hFFFFFF00;
            end
            OP_LH, OP_LHU: begin
                v = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
                if (op == OP_LH && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
        if (op == OP_SB) return 4'(8 >> (a % 4));
        if (op == OP_SH) return ((a % 4) >= 2) ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] sd);
        if (op == OP_SB) return (sd % 256) * 32'h01010101;
        if (op == OP_SH) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    // Runs one instruction; ack arrives in the lat-th REQ cycle
    task automatic apply_stimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rd, input int lat,
                                  input logic [31:0] exp_load, input logic [31:0] exp_addr,
                                  input logic exp_we, input logic [3:0] exp_be,
                                  input logic [31:0] exp_wdata, input logic exp_mis);
        int stall_cnt = 0;
        int req_cnt   = 0;
        int done_cyc  = -1;
        int exp_done;
        logic [31:0] cap_addr = '0, cap_wdata = '0;
        logic [3:0]  cap_be = '0;
        logic        cap_we = 1'b0;
        logic        stable = 1'b1;
        logic        obs_mis = 1'b0;
        logic [31:0] obs_load = '0;

        @(posedge clk); #1;
        start = 1'b1; memOp = op; addr = a; storeData = sd;
        dmemAck = 1'b0; dmemRdata = $urandom;
        @(negedge clk);
        check_output({tag, ":done_pulse"}, 32'(done), 32'd0);
        check_output({tag, ":no_early_req"}, 32'(dmemReq), 32'd0);
        if (stall) stall_cnt++;

        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            dmemAck   = (c == lat);
            dmemRdata = (c == lat) ? rd : $urandom;
            @(negedge clk);
            if (stall) stall_cnt++;
            if (dmemReq) begin
                if (req_cnt == 0) begin
                    cap_addr = dmemAddr; cap_we = dmemWe; cap_be = dmemByteEn; cap_wdata = dmemWdata;
                end else if (cap_addr !== dmemAddr || cap_we !== dmemWe ||
                             cap_be !== dmemByteEn || cap_wdata !== dmemWdata) begin
                    stable = 1'b0;
                end
                req_cnt++;
            end
            if (done) begin
                done_cyc = c; obs_mis = misalign; obs_load = loadData;
                break;
            end
        end

        exp_done = exp_mis ? 1 : lat + 1;
        check_output({tag, ":done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check_output({tag, ":stall_cycles"}, 32'(stall_cnt), 32'(exp_done));
        check_output({tag, ":req_cycles"}, 32'(req_cnt), exp_mis ? 32'd0 : 32'(lat));
        check_output({tag, ":misalign"}, 32'(obs_mis), 32'(exp_mis));
        check_output({tag, ":loadData"}, obs_load, exp_load);
        if (!exp_mis) begin
            check_output({tag, ":dmemAddr"}, cap_addr, exp_addr);
            check_output({tag, ":dmemWe"}, 32'(cap_we), 32'(exp_we));
            check_output({tag, ":byteEn"}, 32'(cap_be), 32'(exp_be));
            check_output({tag, ":req_stable"}, 32'(stable), 32'd1);
            if (exp_we) check_output({tag, ":wdata"}, cap_wdata, exp_wdata);
        end
    endtask

    task automatic run_model(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd, input int lat);
        logic mis;
        logic [31:0] exp_ld;
        mis    = m_misaligned(op, a);
        exp_ld = (m_is_load(op) && !mis) ? m_load(op, a, rd) : model_ld;
        apply_stimulus(tag, op, a, sd, rd, lat, exp_ld, a & 32'hFFFFFFFC, !m_is_load(op),
                       m_be(op, a), m_wdata(op, sd), mis);
        model_ld = exp_ld;
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; memOp = OP_LW; addr = 32'h104;
        storeData = 32'h5555AAAA; dmemRdata = '0; dmemAck = 1'b0;

        vecs[0] = '{OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        3, 32'h00000000, 32'h100, 1'b1, 4'b1111, 32'hDEADBEEF};
        vecs[1] = '{OP_LB,  32'h103, 32'h0,        32'h123456F0, 2, 32'hFFFFFFF0, 32'h100, 1'b0, 4'b1111, 32'h0};
        vecs[2] = '{OP_LBU, 32'h103, 32'h0,        32'h123456F0, 1, 32'h000000F0, 32'h100, 1'b0, 4'b1111, 32'h0};
        vecs[3] = '{OP_LH,  32'h102, 32'h0,        32'h12348001, 2, 32'hFFFF8001, 32'h100, 1'b0, 4'b1111, 32'h0};
        vecs[4] = '{OP_LHU, 32'h100, 32'h0,        32'h12348001, 4, 32'h00001234, 32'h100, 1'b0, 4'b1111, 32'h0};
        vecs[5] = '{OP_SB,  32'h201, 32'h000000AB, 32'h0,        1, 32'h00001234, 32'h200, 1'b1, 4'b0100, 32'hABABABAB};
        vecs[6] = '{OP_SH,  32'h302, 32'h0000CAFE, 32'h0,        2, 32'h00001234, 32'h300, 1'b1, 4'b0011, 32'hCAFECAFE};
        vecs[7] = '{OP_LB,  32'h100, 32'h0,        32'h7F000000, 1, 32'h0000007F, 32'h100, 1'b0, 4'b1111, 32'h0};
        vecs[8] = '{OP_LW,  32'h104, 32'h0,        32'hA5A50F0F, 1, 32'hA5A50F0F, 32'h104, 1'b0, 4'b1111, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst:loadData", loadData, 32'd0);
        check_output("rst:stall", 32'(stall), 32'd0);
        check_output("rst:ctrl", {28'd0, done, misalign, dmemReq, dmemWe}, 32'd0);
        check_output("rst:bus", dmemAddr | dmemWdata | 32'(dmemByteEn), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].sd, vecs[i].rd,
                           vecs[i].lat, vecs[i].exp_load, vecs[i].exp_addr, vecs[i].exp_we,
                           vecs[i].exp_be, vecs[i].exp_wdata, 1'b0);
            model_ld = vecs[i].exp_load;
        end

        // Abort an outstanding load with reset, then offer a stray ack
        @(posedge clk); #1;
        start = 1'b1; memOp = OP_LW; addr = 32'h40; dmemAck = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_output("abort:dmemReq", 32'(dmemReq), 32'd0);
        check_output("abort:stall", 32'(stall), 32'd0);
        check_output("abort:loadData", loadData, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            dmemAck = 1'b1; dmemRdata = $urandom;
            @(negedge clk);
            check_output($sformatf("stray_ack%0d", c), {29'd0, dmemReq, done, stall}, 32'd0);
            check_output($sformatf("stray_ld%0d", c), loadData, 32'd0);
            @(posedge clk); #1;
        end
        dmemAck = 1'b0;
        model_ld = '0;

        run_model("lhu_pre", OP_LHU, 32'h100, 32'h0, 32'h12348001, 1);
        run_model("lw_0x102", OP_LW, 32'h102, 32'h0, 32'hCAFEF00D, 2);
`ifndef LSU_MISALIGN_CHECK_EN
        check_output("lw_0x102:wordload", loadData, 32'hCAFEF00D);
`else
        check_output("lw_0x102:unchanged", loadData, 32'h00001234);
`endif

        for (int i = 0; i < 40; i++) begin
            run_model($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), $urandom & 32'h00000FFF,
                      $urandom, $urandom, int'($urandom_range(1, 4)));
        end

        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
